// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter for two masters on one memory port.
// Optional define ARB_TIMEOUT_EN adds a grant-to-abort watchdog.

module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_read,
    input  logic        m0_write,
    input  logic        m0_instr,
    input  logic [19:0] m0_addr,
    input  logic [15:0] m0_wdata,
    output logic        m0_busy,
    output logic        m0_cack,
    output logic        m0_ready,
    output logic        m0_err,

    input  logic        m1_read,
    input  logic        m1_write,
    input  logic        m1_instr,
    input  logic [19:0] m1_addr,
    input  logic [15:0] m1_wdata,
    output logic        m1_busy,
    output logic        m1_cack,
    output logic        m1_ready,
    output logic        m1_err,

    output logic [15:0] m_rdata,

    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_instr_access,
    output logic [19:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_busy,
    input  logic        mem_cack,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_owner;
    logic        r_last_grant;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_instr;
    logic [19:0] r_addr;
    logic [15:0] r_wdata;

    logic        w_req0;
    logic        w_req1;
    logic        w_grant;
    logic        w_pick1;
    logic        w_sel_read;
    logic        w_sel_write;
    logic        w_sel_instr;
    logic [19:0] w_sel_addr;
    logic [15:0] w_sel_wdata;
    logic        w_cack;
    logic        w_done_ok;
    logic        w_timeout;
    logic        w_done;
    logic        w_unused;

    // mem_busy only tells us the controller is occupied; the command is
    // simply held until cack, so it does not steer anything here.
    assign w_unused = mem_busy ^ (TIMEOUT_CYCLES == 0);

    assign w_req0 = m0_read | m0_write;
    assign w_req1 = m1_read | m1_write;

    // On a tie the master that did not win last time gets the port.
    assign w_pick1 = w_req1 & (~w_req0 | ~r_last_grant);
    assign w_grant = (r_state == S_IDLE) & (w_req0 | w_req1);

    assign w_sel_read  = w_pick1 ? m1_read  : m0_read;
    assign w_sel_write = w_pick1 ? m1_write : m0_write;
    assign w_sel_instr = w_pick1 ? m1_instr : m0_instr;
    assign w_sel_addr  = w_pick1 ? m1_addr  : m0_addr;
    assign w_sel_wdata = w_pick1 ? m1_wdata : m0_wdata;

    // A ready in CMD only counts when it rides along with the cack.
    assign w_cack    = (r_state == S_CMD) & mem_cack;
    assign w_done_ok = (w_cack & mem_ready)
                     | ((r_state == S_WAIT) & mem_ready);

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_cnt;

    // Cycles spent on the current transaction; ready in the same cycle wins.
    assign w_timeout = (r_state != S_IDLE)
                     & (r_cnt == TO_LAST)
                     & ~w_done_ok;

    // Watchdog counter: cleared at grant, runs while a command is open.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 8'd0;
        end else if (w_grant) begin
            r_cnt <= 8'd0;
        end else if (r_state != S_IDLE) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign w_done = w_done_ok | w_timeout;

    // Completion and acceptance are steered only to the owning master.
    assign m0_cack  = w_cack & ~r_owner;
    assign m1_cack  = w_cack &  r_owner;
    assign m0_ready = w_done & ~r_owner;
    assign m1_ready = w_done &  r_owner;
    assign m0_err   = w_timeout & ~r_owner;
    assign m1_err   = w_timeout &  r_owner;

    assign m_rdata = w_timeout ? 16'hFFFF
                   : (w_done_ok ? mem_rdata : 16'h0000);

    // Busy is quiet while reset is held so every master output reads 0.
    assign m0_busy = rst & w_req0 & ~m0_ready;
    assign m1_busy = rst & w_req1 & ~m1_ready;

    assign mem_read         = r_mem_read;
    assign mem_write        = r_mem_write;
    assign mem_instr_access = r_instr;
    assign mem_addr         = r_addr;
    assign mem_wdata        = r_wdata;

    // Arbitration FSM: latch the winner's command, hold it to cack, await ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_instr      <= 1'b0;
            r_addr       <= 20'h0;
            r_wdata      <= 16'h0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_owner      <= w_pick1;
                        r_last_grant <= w_pick1;
                        r_mem_read   <= w_sel_read;
                        r_mem_write  <= w_sel_write & ~w_sel_read;
                        r_instr      <= w_sel_instr;
                        r_addr       <= w_sel_addr;
                        r_wdata      <= w_sel_wdata;
                        r_state      <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (w_done) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (mem_cack) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random transactions against mem_arbiter.
// Expected grant order comes from a round-robin model over request masks.

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        m0_read = 0, m0_write = 0, m0_instr = 0;
    logic [19:0] m0_addr = '0;
    logic [15:0] m0_wdata = '0;
    logic        m0_busy, m0_cack, m0_ready, m0_err;

    logic        m1_read = 0, m1_write = 0, m1_instr = 0;
    logic [19:0] m1_addr = '0;
    logic [15:0] m1_wdata = '0;
    logic        m1_busy, m1_cack, m1_ready, m1_err;

    logic [15:0] m_rdata;
    logic        mem_read, mem_write, mem_instr_access;
    logic [19:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_busy = 0, mem_cack = 0, mem_ready = 0;

    int n_vec  = 0;
    int n_fail = 0;
    int m_last = 1;

    bit          e_rd[2];
    bit          e_wr[2];
    bit          e_in[2];
    logic [19:0] e_ad[2];
    logic [15:0] e_wd[2];

    mem_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .m0_read(m0_read), .m0_write(m0_write), .m0_instr(m0_instr),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_busy(m0_busy), .m0_cack(m0_cack),
        .m0_ready(m0_ready), .m0_err(m0_err),
        .m1_read(m1_read), .m1_write(m1_write), .m1_instr(m1_instr),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_busy(m1_busy), .m1_cack(m1_cack),
        .m1_ready(m1_ready), .m1_err(m1_err),
        .m_rdata(m_rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_instr_access(mem_instr_access),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_busy(mem_busy),
        .mem_cack(mem_cack), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] mo(input int m);
        if (m == 0) return {m0_busy, m0_cack, m0_ready, m0_err};
        return {m1_busy, m1_cack, m1_ready, m1_err};
    endfunction

    // Round-robin rule: on a tie the master not granted last time wins.
    function automatic int pick(input bit p0, input bit p1);
        if (p0 && p1) return 1 - m_last;
        return p1 ? 1 : 0;
    endfunction

    task automatic set_req(input int m, input bit rd, input bit wr,
                           input bit ins, input logic [19:0] a,
                           input logic [15:0] d);
        e_rd[m] = rd; e_wr[m] = wr; e_in[m] = ins;
        e_ad[m] = a;  e_wd[m] = d;
        if (m == 0) begin
            m0_read = rd; m0_write = wr; m0_instr = ins;
            m0_addr = a;  m0_wdata = d;
        end else begin
            m1_read = rd; m1_write = wr; m1_instr = ins;
            m1_addr = a;  m1_wdata = d;
        end
    endtask

    task automatic drop(input int m);
        if (m == 0) begin m0_read = 0; m0_write = 0; end
        else begin m1_read = 0; m1_write = 0; end
    endtask

    task automatic scramble(input int m);
        if (m == 0) begin
            m0_addr = 20'($urandom); m0_wdata = 16'($urandom);
            m0_instr = 1'($urandom);
        end else begin
            m1_addr = 20'($urandom); m1_wdata = 16'($urandom);
            m1_instr = 1'($urandom);
        end
    endtask

    task automatic chk_zero(input string t);
        chk({t, "_cmd"}, {mem_read, mem_write, mem_instr_access}, 0);
        chk({t, "_addr"}, mem_addr, 0);
        chk({t, "_wdata"}, mem_wdata, 0);
        chk({t, "_m0"}, mo(0), 0);
        chk({t, "_m1"}, mo(1), 0);
        chk({t, "_rdata"}, m_rdata, 0);
    endtask

    // One full transaction of master `own` with a scripted controller.
    task automatic xact(input int own, input int hold, input bit same,
                        input int wgap, input logic [15:0] rd,
                        input bit pre, input bit wdr);
        int n;
        int oth;
        bit er;
        bit ew;
        n = 0;
        oth = 1 - own;
        er = e_rd[own];
        ew = e_wr[own] & ~e_rd[own];
        @(negedge clk);
        while (!(mem_read || mem_write) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("grant_timely", (n < 20), 1);
        chk("cmd_op", {mem_read, mem_write}, {er, ew});
        chk("cmd_addr", mem_addr, e_ad[own]);
        chk("cmd_wdata", mem_wdata, e_wd[own]);
        chk("cmd_instr", mem_instr_access, e_in[own]);
        if (!pre) begin
            for (int i = 0; i <= hold; i++) begin
                @(posedge clk); #1;
                if (i == 0 && wdr) drop(own);
                scramble(own);
                if (i < hold) begin
                    mem_busy = 1'b1;
                    @(negedge clk);
                    chk("held_op", {mem_read, mem_write}, {er, ew});
                    chk("held_wdata", mem_wdata, e_wd[own]);
                    chk("held_flags", mo(own) & 4'b1100,
                        wdr ? 4'b0000 : 4'b1000);
                end else begin
                    mem_busy = 1'b0;
                    mem_cack = 1'b1;
                    if (same) begin
                        mem_ready = 1'b1;
                        mem_rdata = rd;
                    end
                end
            end
            @(negedge clk);
        end
        chk("cack_op", {mem_read, mem_write}, {er, ew});
        chk("own_cack", mo(own) & 4'b0111, same ? 4'b0110 : 4'b0100);
        chk("oth_cack", mo(oth) & 4'b0111, 4'b0000);
        if (same) begin
            chk("rdata_same", m_rdata, rd);
            chk("busy_end", mo(own) & 4'b1000, 0);
        end else begin
            @(posedge clk); #1;
            mem_cack = 1'b0;
            mem_busy = 1'b0;
            repeat (wgap) begin
                @(negedge clk);
                chk("wait_cmd", {mem_read, mem_write}, 0);
                chk("wait_flags", mo(own) & 4'b0111, 0);
                @(posedge clk); #1;
            end
            mem_ready = 1'b1;
            mem_rdata = rd;
            @(negedge clk);
            chk("own_ready", mo(own) & 4'b0111, 4'b0010);
            chk("oth_ready", mo(oth) & 4'b0111, 4'b0000);
            chk("rdata", m_rdata, rd);
            chk("busy_end", mo(own) & 4'b1000, 0);
        end
        @(posedge clk); #1;
        mem_cack  = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 16'($urandom);
        drop(own);
    endtask

    // Brings m0 into the post-cack wait with no ready supplied.
    task automatic start_wait();
        int n;
        n = 0;
        @(posedge clk); #1;
        set_req(0, 1, 0, 1, 20'hABCDE, 16'h0);
        m_last = pick(1, 0);
        @(negedge clk);
        while (!mem_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("sw_grant", (n < 20), 1);
        @(posedge clk); #1;
        mem_cack = 1'b1;
        @(negedge clk);
        chk("sw_cack", mo(0) & 4'b0111, 4'b0100);
        @(posedge clk); #1;
        mem_cack = 1'b0;
    endtask

    initial begin
        int own;
        int mask;
        int t;
        bit seen;
        bit rdb;
        bit wrb;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        // Tie after reset: continuous requests alternate m0, m1, m0, m1.
        @(posedge clk); #1;
        set_req(0, 1, 0, 0, 20'h00100, 16'h1111);
        set_req(1, 0, 1, 1, 20'h00200, 16'h2222);
        for (int k = 0; k < 4; k++) begin
            own = pick(1, 1);
            m_last = own;
            xact(own, 0, 0, 1, 16'h3000 + 16'(k), 0, 0);
            if (k < 3) begin
                set_req(own, e_rd[own], e_wr[own], e_in[own],
                        e_ad[own], e_wd[own]);
            end
            @(negedge clk);
            chk("tie_gap", {mem_read, mem_write}, 0);
            chk("tie_wait_busy", mo(1 - own) & 4'b1000, 4'b1000);
            if (k == 3) drop(1 - own);
        end
        repeat (3) begin
            @(negedge clk);
            chk("withdrawn_idle", {mem_read, mem_write}, 0);
        end

        // Single read of 0x12345 returning 0xBEEF.
        @(posedge clk); #1;
        set_req(0, 1, 0, 0, 20'h12345, 16'h0000);
        own = pick(1, 0);
        m_last = own;
        xact(own, 0, 0, 2, 16'hBEEF, 0, 0);

        // m1 write held through mem_busy while its data pins change.
        @(posedge clk); #1;
        set_req(1, 0, 1, 0, 20'h00010, 16'hA5A5);
        own = pick(0, 1);
        m_last = own;
        xact(own, 4, 0, 1, 16'h0000, 0, 0);

        // Cack and ready together on the first command cycle.
        @(posedge clk); #1;
        set_req(0, 1, 0, 0, 20'h0F0F0, 16'h0000);
        mem_cack  = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 16'h1357;
        @(negedge clk);
        chk("idle_ignore", mo(0) & 4'b0111, 0);
        own = pick(1, 0);
        m_last = own;
        xact(own, 0, 1, 0, 16'h1357, 1, 0);

        start_wait();
`ifdef ARB_TIMEOUT_EN
        t = 2;
        do begin
            @(negedge clk);
            t++;
        end while (!m0_err && t < 40);
        chk("timeout_cycle", t, 16);
        chk("timeout_flags", mo(0) & 4'b0111, 4'b0011);
        chk("timeout_rdata", m_rdata, 16'hFFFF);
        @(posedge clk); #1;
        drop(0);
        @(negedge clk);
        chk("after_timeout", mo(0), 0);
        start_wait();
        repeat (3) begin
            @(posedge clk); #1;
        end
`else
        seen = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            seen = seen | m0_ready | m0_err;
        end
        chk("no_timeout_ready", seen, 0);
        chk("still_waiting", {m0_busy, mem_read}, 2'b10);
        @(posedge clk); #1;
`endif

        // Reset while waiting for ready clears everything at once.
        mem_ready = 1'b1;
        mem_rdata = 16'h7777;
        rst = 1'b0;
        #1;
        chk_zero("midrst");
        @(posedge clk); #1;
        mem_ready = 1'b0;
        drop(0);
        @(posedge clk); #1;
        rst = 1'b1;
        m_last = 1;

        @(posedge clk); #1;
        set_req(0, 0, 1, 0, 20'h0AAAA, 16'h4242);
        set_req(1, 1, 0, 1, 20'h05555, 16'h2424);
        own = pick(1, 1);
        m_last = own;
        xact(own, 1, 0, 0, 16'h0BAD, 0, 0);
        own = pick(own == 1, own == 0);
        m_last = own;
        xact(own, 0, 0, 1, 16'hCAFE, 0, 0);

        // Random rounds of one or two requesting masters.
        repeat (60) begin
            mask = $urandom_range(1, 3);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            for (int m = 0; m < 2; m++) begin
                if (mask[m]) begin
                    rdb = 1'($urandom_range(0, 1));
                    wrb = rdb ? 1'($urandom_range(0, 1)) : 1'b1;
                    set_req(m, rdb, wrb, 1'($urandom),
                            20'($urandom), 16'($urandom));
                end
            end
            own = pick(mask[0], mask[1]);
            m_last = own;
            xact(own, $urandom_range(0, 3), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3), 16'($urandom), 0,
                 $urandom_range(0, 4) == 0);
            if (mask == 3) begin
                @(negedge clk);
                chk("rr_gap", {mem_read, mem_write}, 0);
                chk("rr_wait_busy", mo(1 - own) & 4'b1000, 4'b1000);
                own = 1 - own;
                m_last = own;
                xact(own, $urandom_range(0, 3), $urandom_range(0, 3) == 0,
                     $urandom_range(0, 3), 16'($urandom), 0,
                     $urandom_range(0, 4) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter for the shared external memory port (SDRAM/RAM controller with busy/cack/ready handshake). It sits between the memory controller and two bus masters: master 0 is the CPU core's combined fetch/data port, and master 1 is a secondary master (DMA or debug loader). It serialises their transactions with round-robin priority. It latches address, data and operation at grant, drives the command until the controller accepts it, and routes completion back only to the owning master.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles from grant to forced abort; only used with `ARB_TIMEOUT_EN`. Legal range 2..255.
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `mX_read` (X = 0, 1) in 1: read request; held until `mX_ready`.
- `mX_write` in 1: write request; held until `mX_ready`; read wins if both are set.
- `mX_instr` in 1: instruction-space access flag.
- `mX_addr` in 20: paged address.
- `mX_wdata` in 16: write data.
- `mX_busy` out 1: request pending and not yet completed.
- `mX_cack` out 1: one-cycle pulse, the command was accepted by the controller.
- `mX_ready` out 1: one-cycle pulse, the transaction is complete (read data valid).
- `mX_err` out 1: one-cycle abort pulse (timeout).
- `m_rdata` out 16: read data, shared by both masters; valid only when the owner's `mX_ready` is high.
- `mem_read`, `mem_write` out 1: command to the controller.
- `mem_instr_access` out 1: latched `mX_instr` of the owner.
- `mem_addr` out 20, `mem_wdata` out 16: latched command fields.
- `mem_rdata` in 16, `mem_busy` in 1, `mem_cack` in 1, `mem_ready` in 1: controller handshake.

## Operation
- States: IDLE, CMD, WAIT.
- **IDLE**
  - `req_X = mX_read | mX_write`.
  - If only one master requests, grant it.
  - If both request, grant the master that is not `last_grant`.
  - On grant: latch op, addr, wdata and instr into command registers, set `owner`, set `last_grant := owner`, go to CMD.
- **CMD**
  - `mem_read` or `mem_write` is high from the latched op.
  - The command is held through `mem_busy`; `mem_busy` is informational only.
  - On `mem_cack`: pulse `owner_cack` combinationally in the same cycle, deassert the command next cycle, go to WAIT.
  - If `mem_cack` and `mem_ready` are both high in the same cycle, treat it as cack then ready: pulse both, go to IDLE.
- **WAIT**
  - On `mem_ready`: pass it through combinationally as `owner_ready`; `m_rdata = mem_rdata`; go to IDLE.
- **Busy outputs**
  - `mX_busy = req_X & ~(owner==X & mX_ready)`.
  - Busy is also high while X is waiting for the other master.
- **Request withdrawal**
  - A request dropped before grant is ignored.
  - A request dropped after grant does not cancel; the latched transaction runs to completion and its ready pulse is still issued.
- A `mem_ready` with no cack pending in IDLE is ignored. A `mem_cack` in IDLE is also ignored.
- **Reset values:** state IDLE, `last_grant`=1 (master 0 wins first tie), command registers 0, all outputs 0, `m_rdata`=0.

## Timing
- Request sampled at edge N; `mem_read`/`mem_write` high from N+1.
- Minimum transaction: grant cycle, plus cack cycle, plus ready cycle.
- After ready there is one IDLE cycle before the next grant, so back-to-back commands have a one-cycle gap.
- The master must drop or change its request in the cycle after `mX_ready`. A request still held in the IDLE cycle is treated as a new transaction.
- `mX_cack`, `mX_ready` and `m_rdata` are combinational from the controller inputs. `mem_*` outputs are registered.
- Reset is asynchronous: an assertion mid-transaction clears the command on the spot. No completion is reported.

## Configuration
- **`ARB_TIMEOUT_EN` defined**
  - An 8-bit counter is cleared at grant and increments in CMD and WAIT.
  - When it reaches `TIMEOUT_CYCLES` without `mem_ready`: pulse `owner_err` and `owner_ready` together, force `m_rdata`=16'hFFFF, drop the command, go to IDLE.
  - Ready arriving in the same cycle as the timeout wins, and no error is reported.
- **Not defined**
  - No counter; the arbiter waits indefinitely.
  - `mX_err` is tied 0.

## Test plan
- **Single read:** m0 reads 0x12345; cack at +2 cycles, ready with 0xBEEF at +5 -> `mem_read` high 2 cycles with addr 0x12345; one `m0_ready` pulse with `m_rdata`=0xBEEF; m1 outputs stay 0.
- **Tie after reset:** both masters request continuously -> grants go m0, m1, m0, m1; each ready goes only to its owner; one idle cycle between commands.
- **Busy hold and latching:** m1 writes 0xA5A5 to 0x00010 while `mem_busy`=1 for 4 cycles; m1 changes `m1_wdata` after grant -> `mem_write` held 4+ cycles until cack; `mem_wdata` stays 0xA5A5.
- **Same-cycle cack and ready:** `mem_cack` and `mem_ready` high together on the first command cycle -> `m0_cack` and `m0_ready` pulse in the same cycle; state returns to IDLE.
- **Reset mid-operation:** `rst` driven low in WAIT -> `mem_read`, `mem_write` and every `mX_*` output are 0 immediately; the first request after release goes to m0.
- **Timeout** (`ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16): cack given, no ready -> `m0_err` and `m0_ready` pulse 16 cycles after grant with `m_rdata`=0xFFFF. Without the macro, the arbiter is still in WAIT after 1000 cycles.
